cgra_pe_cfg_seq: RTL and testbench
==================================

CGRA_PE_CFG_SEQ -- requirements
Module: cgra_pe_cfg_seq

Interface
REQ-001 Parameter CTX_DEPTH, default 32, SHALL set the number of 64-bit context frames stored.
REQ-002 Parameter CTX_AW, default 5, SHALL set the context address width, with CTX_DEPTH == 2**CTX_AW.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 wr_en / wr_addr / wr_data  in  1 / CTX_AW / 64  SHALL form the context-memory write port.
REQ-006 start / base_addr / length / iter_cnt  in  1 / CTX_AW / CTX_AW+1 / 8  SHALL carry the program launch request.
REQ-007 stall  in  1  SHALL be the PE-array hold request.
REQ-008 abort  in  1  SHALL be the program cancel request.
REQ-009 config_frame / config_valid  out  64 / 1  SHALL drive the PE configuration inputs.
REQ-010 pc  out  CTX_AW  SHALL be the address of the frame currently presented.
REQ-011 busy / done / wr_err  out  1 / 1 / 1  SHALL report, respectively: running; one-cycle completion pulse; rejected write pulse.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE: wr_en SHALL write wr_data into ctx[wr_addr] at the clock edge.
REQ-014 IDLE: start with length != 0 SHALL do the following at the next edge: enter RUN, set pc = base_addr, load frame_q = ctx[base_addr], load the iteration counter and the frame counter.
REQ-015 IDLE: start with length == 0 SHALL enter DONE directly and issue no frames.
REQ-016 config_frame SHALL be registered frame_q; config_valid SHALL equal (state == RUN) && !stall, combinationally.
REQ-017 RUN with stall = 0: the current frame counts as issued, and pc SHALL advance by 1 modulo CTX_DEPTH (wraps from CTX_DEPTH-1 to 0), with frame_q reloaded from the new pc.
REQ-018 RUN with stall = 1: pc, frame_q and all counters SHALL hold, and the frame SHALL NOT count as issued.
REQ-019 At the end of a pass (length frames issued), the iteration counter SHALL decrement, and pc and frame_q SHALL reload from base_addr if passes remain.
REQ-020 After the final frame of the final pass is issued, the FSM SHALL enter DONE; config_valid = 0 there.
REQ-021 DONE SHALL assert done for exactly one cycle and return to IDLE at the next edge.
REQ-022 iter_cnt == 0 SHALL be treated as 1.
REQ-023 base_addr, length and iter_cnt SHALL be captured on start; later input changes SHALL have no effect.
REQ-024 busy SHALL be 1 in RUN and DONE and 0 in IDLE; start while busy SHALL be ignored.
REQ-025 wr_en while busy SHALL NOT modify memory and SHALL pulse wr_err for one cycle.
REQ-026 abort in RUN SHALL force IDLE at the next edge with no done pulse; abort has priority over stall and over completion.
REQ-027 Simultaneous start and wr_en in IDLE: the write SHALL complete, and the launch SHALL read the pre-write contents when wr_addr == base_addr.

Reset
REQ-028 While rst is asserted, outputs SHALL be: state = IDLE, pc = 0, frame_q = 0, config_valid = 0, busy = 0, done = 0, wr_err = 0, counters = 0.
REQ-029 Context memory contents SHALL NOT be reset.
REQ-030 Reset mid-RUN SHALL drop config_valid asynchronously, with no done pulse.

Configuration
REQ-031 Macro CGRA_CFG_SEQ_LOOP_EN defined: iter_cnt multi-pass looping per REQ-019/REQ-022 SHALL be implemented.
REQ-032 Macro CGRA_CFG_SEQ_LOOP_EN undefined: iter_cnt SHALL be ignored, every program SHALL run exactly one pass, and no iteration counter SHALL exist.

Verification
REQ-033 Load ctx[0..3] = 0x11..0x44, start base = 0, length = 4, iter = 1, no stall -> config_valid high for 4 cycles with frames 0x11, 0x22, 0x33, 0x44, then done pulse 1 cycle later, busy low after that.
REQ-034 Base = 30, length = 4, CTX_DEPTH = 32 -> pc sequence 30, 31, 0, 1; done after the 4th frame.
REQ-035 Base = 2, length = 2, iter = 3 (LOOP_EN) -> frames ctx[2], ctx[3] repeated 3 times (6 valid cycles), single done pulse; without the macro -> 2 valid cycles.
REQ-036 Stall asserted for 3 cycles on the 2nd frame -> config_valid low for 3 cycles, pc held, frame order unchanged, total run lengthened by 3 cycles.
REQ-037 wr_en during RUN -> wr_err pulse, memory unchanged (read back after done); abort on cycle 2 -> IDLE next cycle, done never asserted.
REQ-038 Start with length = 0 -> no valid cycles, done pulse on the cycle after start; rst asserted mid-RUN -> config_valid = 0 immediately, IDLE after release.

Source files
------------

// File: rtl/cgra_pe_cfg_seq.sv
// Context-frame sequencer: streams 64-bit configuration frames from a local store to a CGRA PE array.
// Define CGRA_CFG_SEQ_LOOP_EN to enable multi-pass looping controlled by iter_cnt.
module cgra_pe_cfg_seq #(
  parameter int CTX_DEPTH = 32,
  parameter int CTX_AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CTX_AW-1:0] wr_addr,
  input  logic [63:0]       wr_data,
  input  logic              start,
  input  logic [CTX_AW-1:0] base_addr,
  input  logic [CTX_AW:0]   length,
  input  logic [7:0]        iter_cnt,
  input  logic              stall,
  input  logic              abort,
  output logic [63:0]       config_frame,
  output logic              config_valid,
  output logic [CTX_AW-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  // state   | meaning
  // ST_IDLE | accepting writes and launch requests
  // ST_RUN  | presenting frames, pc walks base..base+length-1 per pass
  // ST_DONE | one-cycle completion pulse, then back to idle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [63:0]       r_ctx [CTX_DEPTH];
  logic [63:0]       r_frame;
  logic [CTX_AW-1:0] r_pc;
  logic [CTX_AW-1:0] r_base;
  logic [CTX_AW:0]   r_len;
  logic [CTX_AW:0]   r_frm_cnt;
  logic              r_wr_err;

  logic              w_launch;
  logic              w_issue;
  logic              w_pass_end;
  logic              w_last;
  logic [CTX_AW-1:0] w_pc_inc;

  assign w_launch   = (r_state == ST_IDLE) && start && (length != '0);
  assign w_issue    = (r_state == ST_RUN) && !stall && !abort;
  assign w_pass_end = (r_frm_cnt == (CTX_AW+1)'(1));
  assign w_pc_inc   = r_pc + 1'b1;

`ifdef CGRA_CFG_SEQ_LOOP_EN
  logic [7:0] r_iter;

  assign w_last = w_pass_end && (r_iter == 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iter <= '0;
    end else if (w_launch) begin
      r_iter <= (iter_cnt == 8'd0) ? 8'd1 : iter_cnt;
    end else if (w_issue && w_pass_end && !w_last) begin
      r_iter <= r_iter - 8'd1;
    end
  end
`else
  logic w_unused_iter;

  assign w_unused_iter = ^iter_cnt;
  assign w_last        = w_pass_end;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    config_valid = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = (length == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        config_valid = !stall;
        if (abort)                w_state_nxt = ST_IDLE;
        else if (!stall && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Store is not reset; a launch in the same cycle as a write reads the old word.
  always_ff @(posedge clk) begin
    if (wr_en && (r_state == ST_IDLE)) r_ctx[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_frame   <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_frm_cnt <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_err <= wr_en && (r_state != ST_IDLE);
      if (w_launch) begin
        r_pc      <= base_addr;
        r_frame   <= r_ctx[base_addr];
        r_base    <= base_addr;
        r_len     <= length;
        r_frm_cnt <= length;
      end else if (w_issue && !w_last) begin
        if (w_pass_end) begin
          r_pc      <= r_base;
          r_frame   <= r_ctx[r_base];
          r_frm_cnt <= r_len;
        end else begin
          r_pc      <= w_pc_inc;
          r_frame   <= r_ctx[w_pc_inc];
          r_frm_cnt <= r_frm_cnt - 1'b1;
        end
      end
    end
  end

  assign config_frame = r_frame;
  assign pc           = r_pc;
  assign wr_err       = r_wr_err;

endmodule

// File: tb/tb_cgra_pe_cfg_seq.sv
// Randomized self-checking bench for cgra_pe_cfg_seq against a frame-list reference model.
// Honors CGRA_CFG_SEQ_LOOP_EN so expectations follow the build under test.
module tb_cgra_pe_cfg_seq;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
`ifdef CGRA_CFG_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [7:0]    iter_cnt;
  logic          stall;
  logic          abort;
  logic [63:0]   config_frame;
  logic          config_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          wr_err;

  int checks   = 0;
  int failures = 0;
  logic [63:0] m_ctx [DEPTH];

  always #5 clk = ~clk;

  cgra_pe_cfg_seq #(.CTX_DEPTH(DEPTH), .CTX_AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .base_addr(base_addr), .length(length), .iter_cnt(iter_cnt),
    .stall(stall), .abort(abort), .config_frame(config_frame),
    .config_valid(config_valid), .pc(pc), .busy(busy), .done(done), .wr_err(wr_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctx_write(input int a, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    step();
    wr_en    = 1'b0;
    m_ctx[a] = d;
    check("wr_err_idle", wr_err, 0);
  endtask

  // stall_mode: 0 none, 1 random, 2 three cycles on the second frame
  task automatic run_prog(input int base, input int len, input int iter, input int stall_mode,
                          input int abort_cyc, input int wr_cyc, input bit start_wr);
    logic [63:0] ef[$];
    int          ep[$];
    logic [63:0] old_base;
    logic [63:0] nd;
    int passes, idx, nrun, nst, ndone, st3;
    bit fin, aborted;
    passes   = LOOP ? ((iter == 0) ? 1 : iter) : 1;
    old_base = m_ctx[base];
    nd       = {$urandom, $urandom};
    if (start_wr) m_ctx[base] = nd;
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < len; k++) begin
        ep.push_back((base + k) % DEPTH);
        ef.push_back(m_ctx[(base + k) % DEPTH]);
      end
    if (start_wr && len > 0) ef[0] = old_base;

    start     = 1'b1;
    base_addr = base[AW-1:0];
    length    = len[AW:0];
    iter_cnt  = iter[7:0];
    if (start_wr) begin
      wr_en = 1'b1; wr_addr = base[AW-1:0]; wr_data = nd;
    end
    step();
    start     = 1'b0;
    wr_en     = 1'b0;
    base_addr = AW'($urandom);
    length    = (AW+1)'($urandom);
    iter_cnt  = 8'($urandom);

    idx = 0; nrun = 0; nst = 0; ndone = 0; st3 = 0; fin = 0; aborted = 0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      case (stall_mode)
        1:       stall = ($urandom_range(0, 3) == 0);
        2:       stall = (idx == 1) && (st3 < 3);
        default: stall = 1'b0;
      endcase
      abort = (cyc == abort_cyc);
      if (cyc == wr_cyc) begin
        wr_en = 1'b1; wr_addr = base[AW-1:0]; wr_data = {$urandom, $urandom};
      end else begin
        wr_en = 1'b0;
      end
      #1;
      check("wr_err", wr_err, (wr_cyc >= 0) && (cyc == wr_cyc + 1));
      if (done) begin
        ndone++;
        fin = 1;
      end else if (busy) begin
        nrun++;
        check("cfg_valid", config_valid, !stall);
        if (stall) begin
          nst++;
          if (stall_mode == 2) st3++;
        end
        if (config_valid && !abort) begin
          if (idx < ef.size()) begin
            check("pc", pc, ep[idx]);
            check("frame", config_frame, ef[idx]);
          end else begin
            check("extra_frame", idx, ef.size());
          end
          idx++;
        end
      end else begin
        check("early_idle", busy, 1);
        fin = 1;
      end
      if (abort) begin
        aborted = 1;
        fin     = 1;
      end
      step();
    end
    stall = 1'b0; abort = 1'b0; wr_en = 1'b0;
    if (aborted) begin
      check("abort_idle", busy, 0);
      check("abort_no_done", done, 0);
      check("abort_done_cnt", ndone, 0);
    end else begin
      check("done_cnt", ndone, 1);
      check("frames", idx, ef.size());
      check("run_cycles", nrun, ef.size() + nst);
      if (stall_mode == 2 && ef.size() > 1) check("stall_cycles", nst, 3);
      check("idle_after", busy, 0);
      check("done_once", done, 0);
    end
  endtask

  task automatic reset_mid_run();
    start = 1'b1; base_addr = 5'd4; length = 6'd8; iter_cnt = 8'd1;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_valid", config_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", config_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pc", pc, 0);
    check("rst_frame", config_frame, 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    base_addr = '0; length = '0; iter_cnt = '0; stall = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 0);
    check("reset_frame", config_frame, 0);
    check("reset_valid", config_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wr_err", wr_err, 0);
    rst = 1'b0;
    step();

    for (int a = 0; a < DEPTH; a++) ctx_write(a, {$urandom, $urandom});
    ctx_write(0, 64'h11);
    ctx_write(1, 64'h22);
    ctx_write(2, 64'h33);
    ctx_write(3, 64'h44);

    run_prog(0, 4, 1, 0, -1, -1, 0);
    run_prog(30, 4, 1, 0, -1, -1, 0);
    run_prog(2, 2, 3, 0, -1, -1, 0);
    run_prog(0, 4, 1, 2, -1, -1, 0);
    run_prog(5, 6, 1, 0, -1, 2, 0);
    run_prog(5, 6, 1, 0, -1, -1, 0);
    run_prog(8, 6, 2, 0, 2, -1, 0);
    run_prog(3, 0, 1, 0, -1, -1, 0);
    run_prog(10, 3, 2, 0, -1, -1, 1);
    run_prog(31, 2, 0, 1, -1, -1, 0);
    reset_mid_run();

    for (int t = 0; t < 30; t++) begin
      int b, l, it, ab, wc;
      b  = $urandom_range(0, DEPTH - 1);
      l  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      it = $urandom_range(0, 3);
      ab = (l > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, l - 1) : -1;
      wc = (l > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(0, l - 2) : -1;
      run_prog(b, l, it, $urandom_range(0, 1), ab, wc, $urandom_range(0, 1) == 1);
    end
    run_prog(0, DEPTH, 1, 0, -1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
